// File: rtl/series_ctrl.sv
// rtl/series_ctrl.sv - control FSM sequencing a multiply/accumulate series datapath
// Optional run cancellation is compiled in with SERIES_CTRL_ABORT_EN.
module series_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             abort,
  output logic             ldx,
  output logic             init_t,
  output logic             init_E,
  output logic             init_cnt,
  output logic             ldt,
  output logic [1:0]       sel,
  output logic             ldE,
  output logic             cnt_en,
  output logic             sub,
  output logic             ready,
  output logic             done,
  output logic [CNT_W-1:0] term_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_LOAD, S_MULT, S_ADD, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] n_lat_q, n_lat_d;
  logic [1:0]       mode_q, mode_d;
  logic             kill;
  logic             last_k;
  logic             last_term;

`ifdef SERIES_CTRL_ABORT_EN
  assign kill = abort && (state_q != S_IDLE);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign kill = 1'b0;
`endif

  // sin/cos need three multiply steps per term, Ln/exp two.
  assign last_k    = (k_q == (mode_q[1] ? 2'd2 : 2'd1));
  assign last_term = (idx_q == (n_lat_q - ONE));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    n_lat_d = n_lat_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_START;
      S_START: if (!start) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_MULT;
        k_d     = 2'd0;
        idx_d   = '0;
        mode_d  = mode;
        n_lat_d = (n_terms == '0) ? ONE : n_terms;
      end
      S_MULT: begin
        if (last_k) begin
          state_d = S_ADD;
          k_d     = 2'd0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_ADD: begin
        if (last_term) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MULT;
          idx_d   = idx_q + ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) begin
      state_d = S_IDLE;
      k_d     = 2'd0;
      idx_d   = idx_q;
      mode_d  = mode_q;
      n_lat_d = n_lat_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      idx_q   <= '0;
      mode_q  <= 2'd0;
      n_lat_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      n_lat_q <= n_lat_d;
    end
  end

  always_comb begin
    ldx      = 1'b0;
    init_t   = 1'b0;
    init_E   = 1'b0;
    init_cnt = 1'b0;
    ldt      = 1'b0;
    sel      = 2'd0;
    ldE      = 1'b0;
    cnt_en   = 1'b0;
    sub      = 1'b0;
    done     = 1'b0;
    ready    = (state_q == S_IDLE);
    term_idx = idx_q;
    if (!kill) begin
      case (state_q)
        S_LOAD: begin
          ldx      = 1'b1;
          init_t   = 1'b1;
          init_E   = 1'b1;
          init_cnt = 1'b1;
        end
        S_MULT: begin
          ldt = 1'b1;
          if (k_q == 2'd0)          sel = 2'd1;
          else if (mode_q == 2'd0)  sel = 2'd0;
          else if (mode_q == 2'd1)  sel = 2'd2;
          else                      sel = (k_q == 2'd1) ? 2'd1 : 2'd2;
        end
        S_ADD: begin
          ldE    = 1'b1;
          cnt_en = 1'b1;
          sub    = (mode_q != 2'd1) && idx_q[0];
        end
        S_DONE:  done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/series_ctrl.md
SERIES_CTRL -- requirements
Module: series_ctrl

Interface
REQ-001 Parameter CNT_W, default 4: width of the term counter and of n_terms.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 start  in  1  request; a run begins after start rises and then falls.
REQ-005 mode  in  2  series select: 0 Ln, 1 exp, 2 sin, 3 cos; latched in LOAD.
REQ-006 n_terms  in  CNT_W  number of terms; latched in LOAD; the value 0 is treated as 1.
REQ-007 abort  in  1  cancel the run; honoured only under SERIES_CTRL_ABORT_EN.
REQ-008 ldx, init_t, init_E, init_cnt  out  1 each  datapath load/init strobes, asserted in LOAD only.
REQ-009 ldt  out  1  term register load, asserted in every MULT cycle.
REQ-010 sel  out  2  multiplier operand select (see REQ-017).
REQ-011 ldE, cnt_en  out  1 each  accumulator load and term counter advance, asserted in ADD only.
REQ-012 sub  out  1  accumulator subtracts when 1; valid whenever ldE=1.
REQ-013 ready  out  1  high in IDLE only.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 term_idx  out  CNT_W  current 0-based term index.

Function
REQ-016 States: IDLE, START, LOAD, MULT, ADD, DONE. Transitions:
- IDLE goes to START when start=1, else stays in IDLE.
- START stays while start=1, then goes to LOAD.
- LOAD goes to MULT.
- MULT stays for S cycles (step counter k=0..S-1), then goes to ADD.
- ADD goes to DONE if term_idx==n_lat-1, else to MULT with term_idx incremented and k cleared.
- DONE goes to IDLE.
REQ-017 Per-mode multiply schedule (S steps, sel value per step):
- Ln: S=2, sel = 1, 0.
- exp: S=2, sel = 1, 2.
- sin and cos: S=3, sel = 1, 1, 2.
REQ-018 sub in ADD:
- exp: sub=0 always.
- Ln, sin, cos: sub = term_idx[0], so terms alternate add, subtract, add, ...
REQ-019 Latency: with LOAD in cycle L, done=1 in cycle L+1+n_lat*(S+1), and ready=1 in the following cycle.
REQ-020 Outputs not named as asserted in the current state are 0; outputs are a combinational function of state, k, term_idx and the latched mode.
REQ-021 start, mode and n_terms are ignored outside IDLE, START and LOAD; changes after LOAD do not affect the run.
REQ-022 term_idx resets to 0 in LOAD and holds its final value through DONE and IDLE until the next LOAD.
REQ-023 When n_lat=2^CNT_W-1, term_idx reaches its maximum without wrapping.

Reset
REQ-024 While rst_n=0, state is IDLE and k, term_idx and the latched mode and n_terms are 0; ready=1 and all other outputs are 0.
REQ-025 Assertion of rst_n mid-run returns the block to IDLE immediately; no done pulse is produced and the run is not resumed on release.

Configuration
REQ-026 Macro SERIES_CTRL_ABORT_EN:
- When defined: abort=1 in any state other than IDLE forces the next state to IDLE and forces all strobes (including ldE and done) to 0 in that cycle.
- When defined and abort coincides with the final ADD: abort wins, ldE=0 and no done pulse is produced.
- When undefined: the abort port exists and is ignored.

Verification
REQ-027 mode=0, n_terms=4: start pulse -> sel sequence 1,0 per term, sub 0,1,0,1, done at L+13, then ready=1.
REQ-028 mode=1, n_terms=5 -> sel sequence 1,2 per term, sub always 0, five ldE pulses, done at L+16.
REQ-029 mode=2, n_terms=3 -> three ldt pulses per term with sel 1,1,2, done at L+13; repeat with n_terms=0 -> one term, done at L+5.
REQ-030 Hold start=1 for 5 cycles -> remains in START (ready=0, no ldx) until start falls; LOAD follows on the next cycle.
REQ-031 Drive rst_n=0 during MULT of term 2 -> all outputs match REQ-024 immediately, no done pulse; a subsequent run completes normally.
REQ-032 With SERIES_CTRL_ABORT_EN defined, abort=1 in the final ADD -> ldE=0, no done pulse, ready=1 next cycle; without the macro, the same stimulus -> normal completion with done.
